mem_stage_ctrl: RTL and testbench

- Memory-stage controller. Consumes the EXE_to_MEM pipeline register outputs and performs data-memory accesses over a req/ready handshake to a multi-cycle data memory or cache.
- Handles word loads/stores (LW/SW) and byte loads/stores (LB/SB). SB is done as read-modify-write.
- Drives freeze back to the pipeline registers while an access is outstanding. Delivers load data to the MEM/WB register.

---
 rtl/mem_stage_pkg.sv | 28 ++
 rtl/mem_stage_ctrl_if.sv | 19 +
 rtl/byte_lane_unit.sv | 24 ++
 rtl/mem_stage_ctrl.sv | 122 ++++++++++++
 tb/tb_mem_stage_ctrl.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/mem_stage_pkg.sv
// Shared types and helpers for the memory-stage controller.
package mem_stage_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [1:0] LANE0 = 2'd0;
  localparam logic [1:0] LANE1 = 2'd1;
  localparam logic [1:0] LANE2 = 2'd2;
  localparam logic [1:0] LANE3 = 2'd3;

  // Bit shift that moves the addressed byte down to word[7:0]
  function automatic logic [4:0] lane_shift(input logic [1:0] offset, input logic big_endian);
    logic [1:0] lane;
    case (offset)
      LANE0:   lane = big_endian ? LANE3 : LANE0;
      LANE1:   lane = big_endian ? LANE2 : LANE1;
      LANE2:   lane = big_endian ? LANE1 : LANE2;
      default: lane = big_endian ? LANE0 : LANE3;
    endcase
    return {lane, 3'b000};
  endfunction

endpackage

// File: rtl/mem_stage_ctrl_if.sv
// Request/ready bus between the memory-stage controller and data memory.
interface mem_stage_ctrl_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_ready;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_rdata, dmem_ready
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_rdata, dmem_ready
  );
endinterface

// File: rtl/byte_lane_unit.sv
// Byte extraction (sign-extended) and byte merge for LB/SB.
module byte_lane_unit
  import mem_stage_pkg::*;
#(
  parameter bit BIG_ENDIAN = 1'b0
) (
  input  logic [31:0] word_i,
  input  logic [1:0]  offset_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] byte_sext_o,
  output logic [31:0] merged_o
);

  logic [4:0]  shamt;
  logic [31:0] shifted;
  logic [7:0]  laneByte;

  assign shamt       = lane_shift(offset_i, BIG_ENDIAN);
  assign shifted     = word_i >> shamt;
  assign laneByte    = shifted[7:0];
  assign byte_sext_o = {{24{laneByte[7]}}, laneByte};
  assign merged_o    = (word_i & ~(32'h0000_00FF << shamt)) | ({24'h0, byte_i} << shamt);

endmodule

// File: rtl/mem_stage_ctrl.sv
// Memory-stage controller: LW/SW/LB/SB over a req/ready data-memory bus,
// freezing the pipeline while an access is outstanding.
module mem_stage_ctrl
  import mem_stage_pkg::*;
#(
  parameter bit BIG_ENDIAN = 1'b0
) (
  input  logic               clk,
  input  logic               rst_b,
  input  logic               cache_en,
  input  logic               mem_write,
  input  logic               mem_to_reg,
  input  logic               is_LB_SB,
  input  logic [31:0]        alu_result,
  input  logic [31:0]        rt_data,
  mem_stage_ctrl_if.master   dmem,
  output logic [31:0]        mem_data,
  output logic               freeze,
  output logic               misaligned
);

  state_t      state_q, state_d;
  logic [31:0] wordAddr_q, wordAddr_d;
  logic [1:0]  offset_q, offset_d;
  logic [31:0] buffer_q, buffer_d;
  logic        isStore_q, isStore_d;
  logic        isByte_q, isByte_d;
  logic [31:0] memData_q, memData_d;
  logic        misaligned_q, misaligned_d;

  logic [31:0] byteSext;
  logic [31:0] mergedWord;

  // Load data is simply dropped downstream when mem_to_reg is low
  logic unusedMemToReg;
  assign unusedMemToReg = mem_to_reg;

  // buffer_q[7:0] still holds the latched SB byte when the read returns
  byte_lane_unit #(.BIG_ENDIAN(BIG_ENDIAN)) u_lane (
    .word_i      (dmem.dmem_rdata),
    .offset_i    (offset_q),
    .byte_i      (buffer_q[7:0]),
    .byte_sext_o (byteSext),
    .merged_o    (mergedWord)
  );

  assign dmem.dmem_req   = (state_q == RD) || (state_q == WR);
  assign dmem.dmem_we    = (state_q == WR);
  assign dmem.dmem_addr  = wordAddr_q;
  assign dmem.dmem_wdata = buffer_q;
  assign mem_data        = memData_q;
  assign misaligned      = misaligned_q;
  assign freeze          = rst_b && (((state_q == IDLE) && cache_en) ||
                                     (state_q == RD) || (state_q == WR));

  // Next-state and datapath decode for the access sequence
  always_comb begin
    state_d      = state_q;
    wordAddr_d   = wordAddr_q;
    offset_d     = offset_q;
    buffer_d     = buffer_q;
    isStore_d    = isStore_q;
    isByte_d     = isByte_q;
    memData_d    = memData_q;
    misaligned_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (cache_en) begin
          wordAddr_d = {alu_result[31:2], 2'b00};
          offset_d   = alu_result[1:0];
          buffer_d   = rt_data;
          isStore_d  = mem_write;
          isByte_d   = is_LB_SB;
          state_d    = (mem_write && !is_LB_SB) ? WR : RD;
        end
      end
      RD: begin
        if (dmem.dmem_ready) begin
          if (isStore_q) begin
            buffer_d = mergedWord;
            state_d  = WR;
          end else begin
            memData_d    = isByte_q ? byteSext : dmem.dmem_rdata;
            misaligned_d = !isByte_q && (offset_q != 2'b00);
            state_d      = DONE;
          end
        end
      end
      WR: begin
        if (dmem.dmem_ready) begin
          misaligned_d = !isByte_q && (offset_q != 2'b00);
          state_d      = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and buffer registers; reset abandons any access in flight
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q      <= IDLE;
      wordAddr_q   <= '0;
      offset_q     <= '0;
      buffer_q     <= '0;
      isStore_q    <= 1'b0;
      isByte_q     <= 1'b0;
      memData_q    <= '0;
      misaligned_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wordAddr_q   <= wordAddr_d;
      offset_q     <= offset_d;
      buffer_q     <= buffer_d;
      isStore_q    <= isStore_d;
      isByte_q     <= isByte_d;
      memData_q    <= memData_d;
      misaligned_q <= misaligned_d;
    end
  end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed self-checking bench for mem_stage_ctrl with a wait-state memory model.
module tb_mem_stage_ctrl;

  logic        clk = 1'b0;
  logic        rst_b;
  logic        cache_en, mem_write, mem_to_reg, is_LB_SB;
  logic [31:0] alu_result, rt_data;
  logic [31:0] mem_data;
  logic        freeze, misaligned;

  mem_stage_ctrl_if dmemBus();

  mem_stage_ctrl #(.BIG_ENDIAN(1'b0)) dut (
    .clk        (clk),
    .rst_b      (rst_b),
    .cache_en   (cache_en),
    .mem_write  (mem_write),
    .mem_to_reg (mem_to_reg),
    .is_LB_SB   (is_LB_SB),
    .alu_result (alu_result),
    .rt_data    (rt_data),
    .dmem       (dmemBus),
    .mem_data   (mem_data),
    .freeze     (freeze),
    .misaligned (misaligned)
  );

  always #5 clk = ~clk;

  int          vectorCount = 0;
  int          miscompareCount = 0;
  int          waitCfg = 0;
  int          waitLeft = 0;
  logic [31:0] memWord = '0;
  int          writeCount = 0;
  logic [31:0] lastWrAddr = '0, lastWrData = '0, lastRdAddr = '0;
  int          resFreeze, resReq, resCycles, resMisEarly;
  logic [31:0] resData;
  logic        resMis;
  bit          resDone;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    vectorCount++;
    if (actual !== expected) begin
      miscompareCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  // Memory model: answers each request after waitCfg wait cycles
  initial begin
    dmemBus.dmem_ready = 1'b0;
    dmemBus.dmem_rdata = '0;
    forever begin
      @(negedge clk);
      if (dmemBus.dmem_ready) waitLeft = waitCfg;
      if (dmemBus.dmem_req === 1'b1) begin
        if (waitLeft == 0) begin
          dmemBus.dmem_ready = 1'b1;
          if (dmemBus.dmem_we) begin
            writeCount++;
            lastWrAddr = dmemBus.dmem_addr;
            lastWrData = dmemBus.dmem_wdata;
          end else begin
            dmemBus.dmem_rdata = memWord;
            lastRdAddr = dmemBus.dmem_addr;
          end
        end else begin
          dmemBus.dmem_ready = 1'b0;
          waitLeft--;
        end
      end else begin
        dmemBus.dmem_ready = 1'b0;
        waitLeft = waitCfg;
      end
    end
  end

  task automatic applyStimulus(input logic isStore, input logic isByte, input logic [31:0] addr,
                               input logic [31:0] rt, input int waits);
    int cycles;
    waitCfg = waits;
    @(negedge clk);
    cache_en = 1'b1; mem_write = isStore; mem_to_reg = ~isStore;
    is_LB_SB = isByte; alu_result = addr; rt_data = rt;
    #1;
    resFreeze = 0; resReq = 0; resMisEarly = 0; cycles = 0; resDone = 0;
    while (!resDone && cycles < 40) begin
      cycles++;
      if (freeze) resFreeze++;
      if (dmemBus.dmem_req) resReq++;
      if (!freeze) begin
        resDone = 1; resData = mem_data; resMis = misaligned;
      end else begin
        if (misaligned) resMisEarly++;
        @(negedge clk); #1;
      end
    end
    resCycles = cycles;
    checkOutput("access_completes", 32'(resDone), 32'd1);
  endtask

  task automatic idleCycle();
    @(negedge clk);
    cache_en = 1'b0; mem_write = 1'b0; mem_to_reg = 1'b0; is_LB_SB = 1'b0;
    alu_result = 32'h0000_0999; rt_data = 32'h7777_7777;
    #1;
  endtask

  initial begin
    int wc;
    rst_b = 1'b0; cache_en = 1'b0; mem_write = 1'b0; mem_to_reg = 1'b0;
    is_LB_SB = 1'b0; alu_result = '0; rt_data = '0;
    repeat (2) @(negedge clk);
    #1;
    checkOutput("rst_req", 32'(dmemBus.dmem_req), 32'd0);
    checkOutput("rst_we", 32'(dmemBus.dmem_we), 32'd0);
    checkOutput("rst_addr", dmemBus.dmem_addr, 32'h0);
    checkOutput("rst_wdata", dmemBus.dmem_wdata, 32'h0);
    checkOutput("rst_mem_data", mem_data, 32'h0);
    checkOutput("rst_freeze", 32'(freeze), 32'd0);
    checkOutput("rst_misaligned", 32'(misaligned), 32'd0);
    @(negedge clk); rst_b = 1'b1;

    // LW zero-wait
    memWord = 32'hDEAD_BEEF;
    applyStimulus(1'b0, 1'b0, 32'h0000_0100, 32'h0, 0);
    checkOutput("lw_cycles", 32'(resCycles), 32'd3);
    checkOutput("lw_freeze", 32'(resFreeze), 32'd2);
    checkOutput("lw_req", 32'(resReq), 32'd1);
    checkOutput("lw_addr", lastRdAddr, 32'h0000_0100);
    checkOutput("lw_data", resData, 32'hDEAD_BEEF);
    checkOutput("lw_misaligned", 32'(resMis), 32'd0);

    // LB little-endian, negative and positive byte
    memWord = 32'h8011_2233;
    applyStimulus(1'b0, 1'b1, 32'h0000_0103, 32'h0, 0);
    checkOutput("lb3_addr", lastRdAddr, 32'h0000_0100);
    checkOutput("lb3_data", resData, 32'hFFFF_FF80);
    checkOutput("lb3_misaligned", 32'(resMis), 32'd0);
    applyStimulus(1'b0, 1'b1, 32'h0000_0101, 32'h0, 0);
    checkOutput("lb1_data", resData, 32'h0000_0022);
    checkOutput("lb1_cycles", 32'(resCycles), 32'd3);

    // SB read-modify-write, two wait states per phase
    memWord = 32'h1122_3344;
    wc = writeCount;
    applyStimulus(1'b1, 1'b1, 32'h0000_0202, 32'h0000_00AB, 2);
    checkOutput("sb_wr_addr", lastWrAddr, 32'h0000_0200);
    checkOutput("sb_rd_addr", lastRdAddr, 32'h0000_0200);
    checkOutput("sb_wr_data", lastWrData, 32'h11AB_3344);
    checkOutput("sb_freeze", 32'(resFreeze), 32'd7);
    checkOutput("sb_req", 32'(resReq), 32'd6);
    checkOutput("sb_cycles", 32'(resCycles), 32'd8);
    checkOutput("sb_writes", 32'(writeCount - wc), 32'd1);
    checkOutput("sb_data_hold", resData, 32'h0000_0022);

    // SW misaligned
    applyStimulus(1'b1, 1'b0, 32'h0000_0305, 32'hCAFE_F00D, 0);
    checkOutput("sw_addr", lastWrAddr, 32'h0000_0304);
    checkOutput("sw_data", lastWrData, 32'hCAFE_F00D);
    checkOutput("sw_mis_done", 32'(resMis), 32'd1);
    checkOutput("sw_mis_early", 32'(resMisEarly), 32'd0);
    checkOutput("sw_cycles", 32'(resCycles), 32'd3);
    idleCycle();
    checkOutput("sw_mis_after", 32'(misaligned), 32'd0);

    // Back-to-back LW, SW, non-memory op
    memWord = 32'h1234_5678;
    applyStimulus(1'b0, 1'b0, 32'h0000_0040, 32'h0, 0);
    checkOutput("b2b_lw_data", resData, 32'h1234_5678);
    wc = writeCount;
    applyStimulus(1'b1, 1'b0, 32'h0000_0044, 32'h55AA_55AA, 1);
    checkOutput("b2b_sw_addr", lastWrAddr, 32'h0000_0044);
    checkOutput("b2b_sw_data", lastWrData, 32'h55AA_55AA);
    checkOutput("b2b_sw_freeze", 32'(resFreeze), 32'd3);
    checkOutput("b2b_sw_hold", resData, 32'h1234_5678);
    idleCycle();
    checkOutput("nop_freeze", 32'(freeze), 32'd0);
    checkOutput("nop_req", 32'(dmemBus.dmem_req), 32'd0);
    idleCycle();
    checkOutput("nop_req_next", 32'(dmemBus.dmem_req), 32'd0);
    checkOutput("nop_writes", 32'(writeCount - wc), 32'd1);
    checkOutput("nop_data_hold", mem_data, 32'h1234_5678);

    // Reset during RD wait state
    waitCfg = 5;
    memWord = 32'hAAAA_5555;
    @(negedge clk);
    cache_en = 1'b1; mem_write = 1'b0; mem_to_reg = 1'b1; is_LB_SB = 1'b0;
    alu_result = 32'h0000_0600; rt_data = '0;
    @(negedge clk); #1;
    checkOutput("rstrd_req_before", 32'(dmemBus.dmem_req), 32'd1);
    #2 rst_b = 1'b0;
    #1;
    checkOutput("rstrd_req", 32'(dmemBus.dmem_req), 32'd0);
    checkOutput("rstrd_freeze", 32'(freeze), 32'd0);
    checkOutput("rstrd_mem_data", mem_data, 32'h0);
    idleCycle();
    rst_b = 1'b1;
    #1;
    checkOutput("rstrd_idle_freeze", 32'(freeze), 32'd0);
    memWord = 32'h0BAD_F00D;
    applyStimulus(1'b0, 1'b0, 32'h0000_0500, 32'h0, 1);
    checkOutput("post_rst_lw_data", resData, 32'h0BAD_F00D);
    checkOutput("post_rst_lw_freeze", 32'(resFreeze), 32'd3);
    checkOutput("post_rst_lw_addr", lastRdAddr, 32'h0000_0500);
    idleCycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, miscompareCount);
    $finish;
  end

  // Watchdog so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
